fifo_stream_reader: RTL and testbench

Read-side adapter that drains a show-ahead FIFO read port (data/empty/rd_en, the interface presented by the library's FIFOs) and delivers the words as a valid/ready stream. The block sits in the consumer's clock domain directly behind a FIFO's read port. A two-entry output buffer registers the FIFO pop request, so it never depends combinationally on downstream `i_ready`, while still sustaining one word per cycle.

---
 rtl/fifo_stream_reader_pkg.sv | 15 +
 rtl/wrap_counter.sv | 36 +++
 rtl/fifo_stream_reader.sv | 106 ++++++++++
 tb/tb_fifo_stream_reader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared types for the FIFO-to-stream read adapter: occupancy states and the beat counter width rule.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  // max(1, clog2(n)): a one-beat burst still needs a one-bit counter
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Beat counter for burst framing: counts i_inc pulses 0..MAX-1 then wraps to 0.
// Synchronous active-high reset; count is register-driven (no combinational path from i_inc).
module wrap_counter
  import fifo_stream_reader_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_inc,
  output logic [cnt_width(MAX)-1:0] count
);

  localparam int W = cnt_width(MAX);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_inc) begin
      count_d = (count_q == W'(MAX - 1)) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Show-ahead FIFO read port to valid/ready stream via a 2-entry buffer; pop is registered-state only, 1-cycle latency, 1 word/cycle.
// Backpressure: at most one extra pop after i_ready falls; LIBSV_FIFO_STREAM_READER_LAST_EN adds o_last every BURST_LEN beats.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready
`ifdef LIBSV_FIFO_STREAM_READER_LAST_EN
  ,
  output logic                  o_last
`endif
);

  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("fifo_stream_reader: BURST_LEN must be >= 1");
  end

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] skid_d;
  logic                  fetch;
  logic                  take;

  // The pop request never looks at i_ready, so the FIFO sees no path from the consumer.
  assign fetch   = !i_reset && !i_fifo_empty && (state_q != S_TWO);
  assign o_valid = (state_q != S_EMPTY);
  assign take    = o_valid && i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (fetch) begin
          state_d = S_ONE;
          main_d  = i_fifo_data;
        end
      end
      S_ONE: begin
        if (fetch && take) begin
          main_d = i_fifo_data;
        end else if (fetch) begin
          state_d = S_TWO;
          skid_d  = i_fifo_data;
        end else if (take) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (take) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign o_fifo_rd_en = fetch;
  assign o_data       = main_q;

`ifdef LIBSV_FIFO_STREAM_READER_LAST_EN
  localparam int CNT_W = cnt_width(BURST_LEN);

  logic [CNT_W-1:0] beat_cnt;

  wrap_counter #(
    .MAX(BURST_LEN)
  ) u_beat_cnt (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_inc  (take),
    .count  (beat_cnt)
  );

  assign o_last = o_valid && (beat_cnt == CNT_W'(BURST_LEN - 1));
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: show-ahead FIFO model feeding the adapter, expected words queued at push, monitor pops on each take.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int BL = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          chk_last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          rd_en;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
`ifdef LIBSV_FIFO_STREAM_READER_LAST_EN
  logic          last;
`endif

  int            tests = 0;
  int            fails = 0;
  int            pops  = 0;
  logic          rd_seen = 1'b0;
  logic [DW-1:0] fifo_q[$];
  exp_t          exp_q[$];

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_fifo_data (fifo_data),
    .i_fifo_empty(fifo_empty),
    .o_fifo_rd_en(rd_en),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready)
`ifdef LIBSV_FIFO_STREAM_READER_LAST_EN
    ,
    .o_last      (last)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endfunction

  task automatic push(input logic [DW-1:0] w, input logic lst, input logic cl);
    exp_t e;
    e.data     = w;
    e.last     = lst;
    e.chk_last = cl;
    fifo_q.push_back(w);
    exp_q.push_back(e);
    refresh();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // FIFO model: a pop requested before the edge removes the head just after it
  always @(negedge clk) rd_seen = rd_en;

  always @(posedge clk) begin
    if (rd_seen) begin
      #1;
      chk("pop_nonempty", (fifo_q.size() != 0), 1);
      if (fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        pops++;
      end
      refresh();
    end
  end

  // Scoreboard monitor: every take must match the oldest outstanding word
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL stream_extra: got %0h, expected no word", data);
      end else begin
        e = exp_q.pop_front();
        chk("stream_order", data, e.data);
`ifdef LIBSV_FIFO_STREAM_READER_LAST_EN
        if (e.chk_last) chk("o_last_on_take", last, e.last);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] s1[4];
    logic [DW-1:0] s2[5];
    int            base;
    s1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    s2 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

    rst        = 1'b1;
    ready      = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    for (int i = 0; i < 4; i++) push(s1[i], 1'b0, 1'b0);

    // Reset with a non-empty FIFO: nothing popped, outputs cleared
    repeat (3) begin
      @(negedge clk);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_valid", valid, 0);
      chk("rst_data", data, 0);
    end
    chk("rst_no_pops", pops, 0);

    // Streaming at full rate
    @(posedge clk); #2;
    rst   = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    chk("first_pop_rd_en", rd_en, 1);
    chk("first_pop_valid", valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stream_valid", valid, 1);
      chk("stream_data", data, s1[k]);
    end
    @(negedge clk);
    chk("stream_done_valid", valid, 0);
    chk("stream_done_rd_en", rd_en, 0);

    // Backpressure: exactly two pops, first word held
    @(posedge clk); #2;
    ready = 1'b0;
    base  = pops;
    for (int i = 0; i < 5; i++) push(s2[i], 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("bp_pop_count", pops - base, 2);
    chk("bp_valid", valid, 1);
    chk("bp_data_held", data, 8'hA1);
    chk("bp_rd_en_stalled", rd_en, 0);

    @(posedge clk); #2;
    ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_release_data", data, s2[k]);
      if (k == 1) chk("fetch_take_rd_en", rd_en, 1);
    end
    @(negedge clk);
    chk("bp_release_done", valid, 0);

    // Reset while holding two words
    @(posedge clk); #2;
    ready = 1'b0;
    base  = pops;
    push(8'hB1, 1'b0, 1'b0);
    push(8'hB2, 1'b0, 1'b0);
    push(8'hB3, 1'b0, 1'b0);
    push(8'hB4, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("mid_pre_pops", pops - base, 2);
    chk("mid_pre_data", data, 8'hB1);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rd_en", rd_en, 0);
    @(negedge clk);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_pops", pops - base, 2);
    chk("mid_rst_fifo_left", fifo_q.size(), 2);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    @(posedge clk); #2;
    rst   = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    chk("mid_restart_rd_en", rd_en, 1);
    @(negedge clk);
    chk("mid_restart_data", data, 8'hB3);
    drain("mid_drain");

`ifdef LIBSV_FIFO_STREAM_READER_LAST_EN
    // Burst framing with irregular ready: last on beats 3 and 6 of 7
    begin
      logic [7:0] pat;
      logic [6:0] lst;
      int         n;
      pat = 8'b1011_0011;
      lst = 7'b010_0100;
      @(posedge clk); #2;
      rst   = 1'b1;
      ready = 1'b0;
      @(posedge clk); #2;
      rst = 1'b0;
      for (int i = 0; i < 7; i++) push(8'hC1 + 8'(i), lst[i], 1'b1);
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
        ready = pat[n % 8];
        @(posedge clk); #2;
        n++;
      end
      ready = 1'b0;
      chk("burst_all_taken", exp_q.size(), 0);
      @(negedge clk);
      chk("burst_cnt_after_7", 32'(dut.u_beat_cnt.count), 1);
      chk("burst_last_idle", last, 0);
    end
`endif

    @(negedge clk);
    chk("final_fifo_empty", fifo_q.size(), 0);
    chk("final_valid", valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
